// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle sequencer: accepts a target duty and walks the PWM duty toward it
// by STEP every HOLD_PERIODS PWM periods, updating only on period boundaries.
//
// state | meaning
// IDLE  | duty held, ready for a new target while enabled
// RAMP  | stepping duty toward the latched target on period_start pulses
module pwm_ramp_ctrl #(
    parameter int DW           = 8,
    parameter int STEP         = 1,
    parameter int HOLD_PERIODS = 4,
    parameter int CW           = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          period_start,
    input  logic          tgt_valid,
    input  logic [DW-1:0] tgt_duty,
    output logic          tgt_ready,
    output logic [DW-1:0] duty,
    output logic          pwm_en,
    output logic          busy,
    output logic          done
);

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    localparam logic [DW:0]   STEP_W    = (DW+1)'(STEP);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_PERIODS - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [DW-1:0] tgt_q, tgt_nxt;
    logic [DW-1:0] duty_nxt, duty_step, diff_dn;
    logic [DW:0]   sum_up;
    logic          done_nxt, busy_nxt;
    logic          accept, step_now;

    assign accept   = tgt_valid & tgt_ready & enable & (state == IDLE);
    assign step_now = (state == RAMP) & period_start & (cnt == HOLD_LAST);

    // Saturating step toward the target: the up-sum carries an extra bit so it
    // cannot wrap, and the down path only subtracts when the gap exceeds STEP.
    always_comb begin
        sum_up    = {1'b0, duty} + STEP_W;
        diff_dn   = duty - tgt_q;
        duty_step = duty;
        if (tgt_q > duty) begin
            duty_step = (sum_up >= {1'b0, tgt_q}) ? tgt_q : sum_up[DW-1:0];
        end else begin
            duty_step = ({1'b0, diff_dn} <= STEP_W) ? tgt_q : (duty - STEP_W[DW-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            tgt_q     <= '0;
            duty      <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            pwm_en    <= 1'b0;
            tgt_ready <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            tgt_q     <= tgt_nxt;
            duty      <= duty_nxt;
            done      <= done_nxt;
            busy      <= busy_nxt;
            pwm_en    <= enable;
            tgt_ready <= (state_nxt == IDLE) & enable;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (accept && (tgt_duty != duty)) state_nxt = RAMP;
                RAMP: if (step_now && (duty_step == tgt_q)) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_nxt  = cnt;
        tgt_nxt  = tgt_q;
        duty_nxt = duty;
        done_nxt = 1'b0;
        busy_nxt = busy;
        if (!enable) begin
            cnt_nxt  = '0;
            tgt_nxt  = '0;
            duty_nxt = '0;
            busy_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    busy_nxt = 1'b0;
                    if (accept) begin
                        tgt_nxt = tgt_duty;
                        cnt_nxt = '0;
                        if (tgt_duty == duty) done_nxt = 1'b1;
                        else                  busy_nxt = 1'b1;
                    end
                end
                RAMP: begin
                    if (period_start) begin
                        if (cnt == HOLD_LAST) begin
                            cnt_nxt  = '0;
                            duty_nxt = duty_step;
                            if (duty_step == tgt_q) begin
                                done_nxt = 1'b1;
                                busy_nxt = 1'b0;
                            end
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    busy_nxt = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed + randomized bench for pwm_ramp_ctrl; expected duty trajectory comes
// from a plain-integer model of the ramp rules.
module tb_pwm_ramp_ctrl;

    localparam int DW   = 8;
    localparam int STEP = 16;
    localparam int HOLD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          period_start;
    logic          tgt_valid;
    logic [DW-1:0] tgt_duty;
    logic          tgt_ready;
    logic [DW-1:0] duty;
    logic          pwm_en;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;
    int duty_m = 0;

    pwm_ramp_ctrl #(.DW(DW), .STEP(STEP), .HOLD_PERIODS(HOLD), .CW(8)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .period_start(period_start),
        .tgt_valid(tgt_valid),
        .tgt_duty(tgt_duty),
        .tgt_ready(tgt_ready),
        .duty(duty),
        .pwm_en(pwm_en),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int step_toward(input int d, input int t);
        if (t > d) return (d + STEP >= t) ? t : d + STEP;
        return (d - t <= STEP) ? t : d - STEP;
    endfunction

    // Accept target t, then walk the ramp; max_steps < 0 runs to completion.
    task automatic ramp(input int t, input bit coin, input int max_steps);
        int steps;
        int gap;
        tgt_valid    = 1'b1;
        tgt_duty     = 8'(t);
        period_start = coin;
        tick();
        tgt_valid    = 1'b0;
        period_start = 1'b0;
        if (t == duty_m) begin
            chk("eq_done", done, 1);
            chk("eq_busy", busy, 0);
            chk("eq_duty", duty, duty_m);
            tick();
            chk("eq_done_clr", done, 0);
            chk("eq_busy_after", busy, 0);
            chk("eq_ready", tgt_ready, 1);
            return;
        end
        chk("acc_busy", busy, 1);
        chk("acc_ready", tgt_ready, 0);
        chk("acc_done", done, 0);
        chk("acc_duty", duty, duty_m);
        steps = 0;
        while (duty_m != t && (max_steps < 0 || steps < max_steps)) begin
            for (int p = 0; p < HOLD; p++) begin
                gap = $urandom_range(0, 2);
                repeat (gap) begin
                    tgt_valid = 1'($urandom_range(0, 1));
                    tgt_duty  = 8'($urandom);
                    tick();
                    tgt_valid = 1'b0;
                    chk("gap_duty", duty, duty_m);
                    chk("gap_ready", tgt_ready, 0);
                end
                period_start = 1'b1;
                tick();
                period_start = 1'b0;
                if (p < HOLD - 1) begin
                    chk("mid_duty", duty, duty_m);
                    chk("mid_busy", busy, 1);
                    chk("mid_done", done, 0);
                end
            end
            duty_m = step_toward(duty_m, t);
            steps++;
            chk("step_duty", duty, duty_m);
            chk("step_done", done, (duty_m == t) ? 1 : 0);
            chk("step_busy", busy, (duty_m != t) ? 1 : 0);
        end
        if (duty_m == t) chk("end_ready", tgt_ready, 1);
    endtask

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        period_start = 1'b0;
        tgt_valid    = 1'b0;
        tgt_duty     = '0;
        tick();
        tick();
        chk("rst_duty", duty, 0);
        chk("rst_pwm_en", pwm_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", tgt_ready, 0);

        reset  = 1'b0;
        enable = 1'b1;
        tick();
        chk("en_pwm_en", pwm_en, 1);
        chk("en_ready", tgt_ready, 1);
        chk("en_duty", duty, 0);

        ramp(64, 1'b0, -1);
        ramp(10, 1'b0, -1);
        ramp(10, 1'b0, -1);
        ramp(0, 1'b0, -1);
        ramp(64, 1'b1, 2);
        chk("pre_dis_duty", duty, 32);

        // Disable mid-ramp with competing period_start and tgt_valid.
        enable       = 1'b0;
        period_start = 1'b1;
        tgt_valid    = 1'b1;
        tgt_duty     = 8'd99;
        tick();
        period_start = 1'b0;
        tgt_valid    = 1'b0;
        duty_m       = 0;
        chk("dis_duty", duty, 0);
        chk("dis_pwm_en", pwm_en, 0);
        chk("dis_ready", tgt_ready, 0);
        chk("dis_busy", busy, 0);
        chk("dis_done", done, 0);
        tick();
        chk("dis_done2", done, 0);
        enable = 1'b1;
        tick();
        chk("reen_ready", tgt_ready, 1);
        chk("reen_pwm_en", pwm_en, 1);
        chk("reen_duty", duty, 0);
        period_start = 1'b1;
        tick();
        period_start = 1'b0;
        chk("reen_hold", duty, 0);

        ramp(200, 1'($urandom_range(0, 1)), 3);
        reset = 1'b1;
        tick();
        duty_m = 0;
        chk("mrst_duty", duty, 0);
        chk("mrst_pwm_en", pwm_en, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_ready", tgt_ready, 0);
        reset = 1'b0;
        tick();
        chk("mrst_rel_ready", tgt_ready, 1);

        for (int i = 0; i < 6; i++) begin
            ramp(int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
